ecc_scrubber: RTL and testbench
===============================

ECC_SCRUBBER -- requirements
Module: ecc_scrubber

Interface
REQ-001 SHALL have parameter AW, default 10, memory address width.
REQ-002 SHALL have parameter DEPTH, default 1024, number of words scrubbed (2..2**AW).
REQ-003 SHALL have parameter CW, default 13, codeword width incl. extended parity.
REQ-004 SHALL have parameter INTERVAL, default 256, idle cycles between scrub reads (>=1).
REQ-005 SHALL have parameter CNT_W, default 16, error counter width.
REQ-006 SHALL have ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- en_i  in  1  scrub enable
- start_i  in  1  skip remaining interval, read now
- clr_i  in  1  clear counters and irq
- mem_req_o  out  1  memory access request
- mem_we_o  out  1  1=write, 0=read
- mem_addr_o  out  AW  access address
- mem_wdata_o  out  CW  write codeword
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  CW  read codeword
- dec_cw_o  out  CW  captured codeword to decoder
- dec_sb_err_i  in  1  decoder single-bit error flag
- dec_db_err_i  in  1  decoder double-bit error flag
- enc_cw_i  in  CW  re-encoded corrected codeword
- sb_cnt_o  out  CNT_W  corrected-error count
- db_cnt_o  out  CNT_W  uncorrectable-error count
- db_addr_o  out  AW  address of last uncorrectable error
- db_irq_o  out  1  sticky uncorrectable-error flag
- busy_o  out  1  state != IDLE
- sweep_done_o  out  1  one-cycle pulse, full sweep done

Function
REQ-007 SHALL implement states IDLE, WAIT, RD_REQ, RD_WAIT, CHECK, WR_REQ.
REQ-008 IDLE: en_i=1 -> WAIT, timer loaded INTERVAL-1.
REQ-009 WAIT: timer decrements each cycle; timer==0 or start_i=1 -> RD_REQ; en_i=0 -> IDLE.
REQ-010 RD_REQ: mem_req_o=1, mem_we_o=0, mem_addr_o=current address; held until mem_gnt_i=1, then -> RD_WAIT; request never withdrawn once raised.
REQ-011 RD_WAIT: on mem_rvalid_i=1 capture mem_rdata_i into codeword register -> CHECK; mem_rvalid_i outside RD_WAIT ignored.
REQ-012 dec_cw_o SHALL equal the codeword register at all times; decoder/encoder path combinational, sampled in CHECK.
REQ-013 CHECK (one cycle): sb flag -> sb_cnt+1, capture enc_cw_i, -> WR_REQ; db flag -> db_cnt+1, db_addr_o<=address, db_irq_o<=1, -> advance; neither -> advance; db flag takes precedence if both set.
REQ-014 WR_REQ: mem_req_o=1, mem_we_o=1, mem_wdata_o=captured enc_cw_i, same address; on mem_gnt_i -> advance.
REQ-015 Advance: address+1, wrap DEPTH-1 -> 0 with sweep_done_o=1 that cycle; next state WAIT (timer reloaded) if en_i=1 else IDLE.
REQ-016 en_i deassert mid-access SHALL complete current word (read, check, writeback) before IDLE.
REQ-017 Counters SHALL saturate at 2**CNT_W-1.
REQ-018 clr_i=1 SHALL zero sb_cnt_o, db_cnt_o, db_irq_o next cycle; clr wins over simultaneous increment/set.
REQ-019 mem_req_o=0, mem_we_o=0 in IDLE, WAIT, RD_WAIT, CHECK.

Reset
REQ-020 Reset SHALL force IDLE, address 0, timer 0, codeword register 0, all outputs 0, including mid-access (outstanding request abandoned).

Configuration
REQ-021 Macro ECC_SCRUB_WRITEBACK_EN defined: WR_REQ and writeback as REQ-013/014.
REQ-022 Macro ECC_SCRUB_WRITEBACK_EN undefined: no WR_REQ state, sb errors counted only, CHECK always advances, mem_we_o constant 0, mem_wdata_o constant 0.

Verification
REQ-023 DEPTH=4, INTERVAL=2, en_i=1, clean memory, gnt immediate -> reads addr 0,1,2,3, sweep_done_o pulse after addr 3, addr wraps to 0, counters 0.
REQ-024 Addr 2 holds single-bit error, writeback enabled -> sb_cnt_o=1, write to addr 2 with corrected codeword, next sweep sb_cnt_o stays 1.
REQ-025 Addr 1 holds double-bit error -> db_cnt_o=1, db_addr_o=1, db_irq_o=1, no write; clr_i pulse -> all 0.
REQ-026 mem_gnt_i held 0 for 5 cycles in RD_REQ -> mem_req_o/mem_addr_o stable 5 cycles, access proceeds on grant.
REQ-027 en_i dropped in RD_WAIT with sb error pending -> writeback completes, then IDLE, busy_o=0.
REQ-028 rst_ni asserted in WR_REQ -> mem_req_o=0 immediately, outputs 0, IDLE after release.

Source files
------------

// File: rtl/ecc_scrubber.sv
// ecc_scrubber: background memory scrubber for SECDED-protected storage.
//
// Periodically reads every word in [0, DEPTH-1], passes the codeword to an
// external combinational decoder, counts corrected and uncorrectable errors,
// and (optionally) writes the re-encoded codeword back on a single-bit error.
//
// Build option:
//   ECC_SCRUB_WRITEBACK_EN  defined   -> single-bit errors are written back via WR_REQ.
//                           undefined -> single-bit errors are only counted; no writes
//                                        are ever issued (mem_we_o/mem_wdata_o tied 0).
//
// Ports:
//   clk_i, rst_ni             clock (rising edge), asynchronous active-low reset
//   en_i                      scrub enable
//   start_i                   skip the rest of the idle interval and read now
//   clr_i                     clear error counters, last-db address and irq
//   mem_req_o/we_o/addr_o/wdata_o, mem_gnt_i, mem_rvalid_i, mem_rdata_i
//                             request/grant memory port, read data returns later
//   dec_cw_o                  captured codeword to the external decoder
//   dec_sb_err_i/db_err_i     decoder error flags, sampled in CHECK
//   enc_cw_i                  corrected, re-encoded codeword from the encoder
//   sb_cnt_o/db_cnt_o         saturating corrected/uncorrectable error counts
//   db_addr_o, db_irq_o       address of last uncorrectable error, sticky flag
//   busy_o                    scrubber not idle
//   sweep_done_o              one-cycle pulse when the last word is retired
module ecc_scrubber #(
  parameter int unsigned AW       = 10,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned CW       = 13,
  parameter int unsigned INTERVAL = 256,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             start_i,
  input  logic             clr_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [CW-1:0]    mem_wdata_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic [CW-1:0]    mem_rdata_i,
  output logic [CW-1:0]    dec_cw_o,
  input  logic             dec_sb_err_i,
  input  logic             dec_db_err_i,
  input  logic [CW-1:0]    enc_cw_i,
  output logic [CNT_W-1:0] sb_cnt_o,
  output logic [CNT_W-1:0] db_cnt_o,
  output logic [AW-1:0]    db_addr_o,
  output logic             db_irq_o,
  output logic             busy_o,
  output logic             sweep_done_o
);

  localparam int unsigned TW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [TW-1:0] TimerLoad = TW'(INTERVAL - 1);
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

`ifdef ECC_SCRUB_WRITEBACK_EN
  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRdReq,
    StRdWait,
    StCheck,
    StWrReq
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StRdReq,
    StRdWait,
    StCheck
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CW-1:0]    cw_q, cw_d;
  logic [CNT_W-1:0] sb_cnt_q, sb_cnt_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [AW-1:0]    db_addr_q, db_addr_d;
  logic             db_irq_q, db_irq_d;
  logic             advance;

`ifdef ECC_SCRUB_WRITEBACK_EN
  logic [CW-1:0]    wdata_q, wdata_d;
`else
  // Encoder output has no consumer when writeback is compiled out.
  logic             unused_enc;
  assign unused_enc = ^enc_cw_i;
`endif

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    addr_d    = addr_q;
    cw_d      = cw_q;
    sb_cnt_d  = sb_cnt_q;
    db_cnt_d  = db_cnt_q;
    db_addr_d = db_addr_q;
    db_irq_d  = db_irq_q;
    advance   = 1'b0;
`ifdef ECC_SCRUB_WRITEBACK_EN
    wdata_d   = wdata_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (en_i) begin
          state_d = StWait;
          timer_d = TimerLoad;
        end
      end

      StWait: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end
        // Disable wins so software can always park the scrubber between words.
        if (!en_i) begin
          state_d = StIdle;
        end else if ((timer_q == '0) || start_i) begin
          state_d = StRdReq;
        end
      end

      // Request stays up until granted, regardless of en_i.
      StRdReq: begin
        if (mem_gnt_i) begin
          state_d = StRdWait;
        end
      end

      StRdWait: begin
        if (mem_rvalid_i) begin
          cw_d    = mem_rdata_i;
          state_d = StCheck;
        end
      end

      StCheck: begin
        if (dec_db_err_i) begin
          if (db_cnt_q != CntMax) begin
            db_cnt_d = db_cnt_q + CNT_W'(1);
          end
          db_addr_d = addr_q;
          db_irq_d  = 1'b1;
          advance   = 1'b1;
        end else if (dec_sb_err_i) begin
          if (sb_cnt_q != CntMax) begin
            sb_cnt_d = sb_cnt_q + CNT_W'(1);
          end
`ifdef ECC_SCRUB_WRITEBACK_EN
          wdata_d = enc_cw_i;
          state_d = StWrReq;
`else
          advance = 1'b1;
`endif
        end else begin
          advance = 1'b1;
        end
      end

`ifdef ECC_SCRUB_WRITEBACK_EN
      StWrReq: begin
        if (mem_gnt_i) begin
          advance = 1'b1;
        end
      end
`endif

      default: begin
        state_d = StIdle;
      end
    endcase

    // Retire the current word: step the address and re-arm or park.
    if (advance) begin
      if (addr_q == LastAddr) begin
        addr_d = '0;
      end else begin
        addr_d = addr_q + AW'(1);
      end
      if (en_i) begin
        state_d = StWait;
        timer_d = TimerLoad;
      end else begin
        state_d = StIdle;
      end
    end

    // Clear has priority over any increment or flag set in the same cycle.
    if (clr_i) begin
      sb_cnt_d  = '0;
      db_cnt_d  = '0;
      db_addr_d = '0;
      db_irq_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      addr_q    <= '0;
      cw_q      <= '0;
      sb_cnt_q  <= '0;
      db_cnt_q  <= '0;
      db_addr_q <= '0;
      db_irq_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      addr_q    <= addr_d;
      cw_q      <= cw_d;
      sb_cnt_q  <= sb_cnt_d;
      db_cnt_q  <= db_cnt_d;
      db_addr_q <= db_addr_d;
      db_irq_q  <= db_irq_d;
    end
  end

`ifdef ECC_SCRUB_WRITEBACK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdata_q <= '0;
    end else begin
      wdata_q <= wdata_d;
    end
  end

  assign mem_req_o   = (state_q == StRdReq) || (state_q == StWrReq);
  assign mem_we_o    = (state_q == StWrReq);
  assign mem_wdata_o = wdata_q;
`else
  assign mem_req_o   = (state_q == StRdReq);
  assign mem_we_o    = 1'b0;
  assign mem_wdata_o = '0;
`endif

  assign mem_addr_o   = addr_q;
  assign dec_cw_o     = cw_q;
  assign sb_cnt_o     = sb_cnt_q;
  assign db_cnt_o     = db_cnt_q;
  assign db_addr_o    = db_addr_q;
  assign db_irq_o     = db_irq_q;
  assign busy_o       = (state_q != StIdle);
  assign sweep_done_o = advance && (addr_q == LastAddr);

endmodule

// File: tb/tb_ecc_scrubber.sv
module tb_ecc_scrubber;

  localparam int unsigned AW       = 3;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned CW       = 13;
  localparam int unsigned INTERVAL = 2;
  localparam int unsigned CNT_W    = 2;

  // Clean codewords; pairwise Hamming distance >= 4 so 1- and 2-bit
  // corruptions are unambiguous for the toy decoder below.
  localparam logic [CW-1:0] GOLDEN [DEPTH] = '{13'h1A5, 13'h0C3, 13'h15A, 13'h0F0};

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             en_i = 1'b0;
  logic             start_i = 1'b0;
  logic             clr_i = 1'b0;
  logic             mem_req_o;
  logic             mem_we_o;
  logic [AW-1:0]    mem_addr_o;
  logic [CW-1:0]    mem_wdata_o;
  logic             mem_gnt_i;
  logic             mem_rvalid_i = 1'b0;
  logic [CW-1:0]    mem_rdata_i = '0;
  logic [CW-1:0]    dec_cw_o;
  logic             dec_sb_err_i;
  logic             dec_db_err_i;
  logic [CW-1:0]    enc_cw_i;
  logic [CNT_W-1:0] sb_cnt_o;
  logic [CNT_W-1:0] db_cnt_o;
  logic [AW-1:0]    db_addr_o;
  logic             db_irq_o;
  logic             busy_o;
  logic             sweep_done_o;

  always #5 clk_i = ~clk_i;

  ecc_scrubber #(
    .AW       (AW),
    .DEPTH    (DEPTH),
    .CW       (CW),
    .INTERVAL (INTERVAL),
    .CNT_W    (CNT_W)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .start_i      (start_i),
    .clr_i        (clr_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .dec_cw_o     (dec_cw_o),
    .dec_sb_err_i (dec_sb_err_i),
    .dec_db_err_i (dec_db_err_i),
    .enc_cw_i     (enc_cw_i),
    .sb_cnt_o     (sb_cnt_o),
    .db_cnt_o     (db_cnt_o),
    .db_addr_o    (db_addr_o),
    .db_irq_o     (db_irq_o),
    .busy_o       (busy_o),
    .sweep_done_o (sweep_done_o)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
  } acc_t;

  acc_t exp_q[$];
  acc_t mon_e;
  int   total = 0;
  int   bad = 0;

  // Memory model: grant is combinational, read data returns one cycle later.
  logic [CW-1:0] mem [DEPTH];
  logic [CW-1:0] load_val [DEPTH];
  logic          load_mem = 1'b0;
  logic          gnt_block = 1'b0;
  logic          wr_block = 1'b0;

  assign mem_gnt_i = mem_req_o & ~gnt_block & ~(mem_we_o & wr_block);

  always @(posedge clk_i) begin
    mem_rvalid_i <= mem_req_o && mem_gnt_i && !mem_we_o;
    mem_rdata_i  <= mem[mem_addr_o[1:0]];
    if (load_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= load_val[i];
    end else if (mem_req_o && mem_gnt_i && mem_we_o) begin
      mem[mem_addr_o[1:0]] <= mem_wdata_o;
    end
  end

  // Toy SECDED decoder: distance 0 to a golden word = clean, 1 = correctable, else double.
  always_comb begin
    dec_sb_err_i = 1'b0;
    dec_db_err_i = 1'b1;
    enc_cw_i     = dec_cw_o;
    for (int i = 0; i < DEPTH; i++) begin
      if ($countones(dec_cw_o ^ GOLDEN[i]) == 0) dec_db_err_i = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if ($countones(dec_cw_o ^ GOLDEN[i]) == 1) begin
        dec_sb_err_i = 1'b1;
        dec_db_err_i = 1'b0;
        enc_cw_i     = GOLDEN[i];
      end
    end
  end

  // Monitor: every granted access must match the head of the expected queue.
  always @(negedge clk_i) begin
    if (rst_ni && mem_req_o && mem_gnt_i) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL access_unexpected: got we=%0b addr=%0d data=%0h, required no access",
                 mem_we_o, mem_addr_o, mem_wdata_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_we_o !== mon_e.we || mem_addr_o !== mon_e.addr ||
            (mon_e.we && mem_wdata_o !== mon_e.data)) begin
          bad++;
          $display("FAIL access: got we=%0b addr=%0d data=%0h, required we=%0b addr=%0d data=%0h",
                   mem_we_o, mem_addr_o, mem_wdata_o, mon_e.we, mon_e.addr, mon_e.data);
        end
      end
    end
    if (rst_ni && sweep_done_o) begin
      total++;
      if (mem_addr_o !== AW'(DEPTH - 1)) begin
        bad++;
        $display("FAIL sweep_addr: got %0d, required %0d", mem_addr_o, DEPTH - 1);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_load();
    load_mem = 1'b1;
    tick();
    load_mem = 1'b0;
  endtask

  task automatic push_rd(input int a);
    exp_q.push_back(acc_t'{we: 1'b0, addr: AW'(a), data: '0});
  endtask

  task automatic push_wr(input int a, input logic [CW-1:0] d);
    exp_q.push_back(acc_t'{we: 1'b1, addr: AW'(a), data: d});
  endtask

  task automatic push_sweep();
    for (int a = 0; a < DEPTH; a++) push_rd(a);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk_i);
    while (busy_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check(name, 32'(busy_o), 32'd0);
  endtask

  // Wait for the wrap pulse, stop at the next WAIT, and confirm every access was seen.
  task automatic finish_sweep(input string name);
    int n = 0;
    @(negedge clk_i);
    while (!sweep_done_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check({name, "_done"}, 32'(sweep_done_o), 32'd1);
    tick();
    en_i = 1'b0;
    wait_idle({name, "_idle"});
    check({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
  endtask

  initial begin
    int n;
    load_val = GOLDEN;
    do_load();
    tick();
    // Reset values
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_we", 32'(mem_we_o), 32'd0);
    check("rst_addr", 32'(mem_addr_o), 32'd0);
    check("rst_wdata", 32'(mem_wdata_o), 32'd0);
    check("rst_cw", 32'(dec_cw_o), 32'd0);
    check("rst_cnts", {sb_cnt_o, db_cnt_o, db_addr_o, db_irq_o}, 32'd0);
    check("rst_sweep", 32'(sweep_done_o), 32'd0);
    rst_ni = 1'b1;
    tick();

    // Clean sweep
    push_sweep();
    en_i = 1'b1;
    finish_sweep("clean");
    check("clean_sb", 32'(sb_cnt_o), 32'd0);
    check("clean_db", 32'(db_cnt_o), 32'd0);
    check("clean_wrap_addr", 32'(mem_addr_o), 32'd0);

    // Single-bit error at address 2
    load_val = GOLDEN;
    load_val[2] = GOLDEN[2] ^ 13'h004;
    do_load();
    push_rd(0); push_rd(1); push_rd(2);
`ifdef ECC_SCRUB_WRITEBACK_EN
    push_wr(2, GOLDEN[2]);
`endif
    push_rd(3);
    en_i = 1'b1;
    finish_sweep("sb1");
    check("sb1_cnt", 32'(sb_cnt_o), 32'd1);
    check("sb1_db", 32'(db_cnt_o), 32'd0);
`ifdef ECC_SCRUB_WRITEBACK_EN
    check("sb1_mem_fixed", 32'(mem[2]), 32'(GOLDEN[2]));
`endif
    push_sweep();
    en_i = 1'b1;
    finish_sweep("sb2");
`ifdef ECC_SCRUB_WRITEBACK_EN
    check("sb2_cnt", 32'(sb_cnt_o), 32'd1);
`else
    check("sb2_cnt", 32'(sb_cnt_o), 32'd2);
`endif
    pulse_clr();
    check("sb_clr", 32'(sb_cnt_o), 32'd0);

    // Double-bit error at address 1: counted, never written
    load_val = GOLDEN;
    load_val[1] = GOLDEN[1] ^ 13'h00C;
    do_load();
    push_sweep();
    en_i = 1'b1;
    finish_sweep("db");
    check("db_cnt", 32'(db_cnt_o), 32'd1);
    check("db_addr", 32'(db_addr_o), 32'd1);
    check("db_irq", 32'(db_irq_o), 32'd1);
    check("db_sb", 32'(sb_cnt_o), 32'd0);
    pulse_clr();
    check("db_clr", {sb_cnt_o, db_cnt_o, db_addr_o, db_irq_o}, 32'd0);

    // Saturation of the 2-bit counter
    for (int k = 1; k <= 4; k++) begin
      push_sweep();
      en_i = 1'b1;
      finish_sweep("sat");
      check("sat_db_cnt", 32'(db_cnt_o), (k < 3) ? k : 3);
    end
    pulse_clr();

    // Grant stalled for five cycles
    load_val = GOLDEN;
    do_load();
    push_sweep();
    gnt_block = 1'b1;
    en_i = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!mem_req_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_req", 32'(mem_req_o), 32'd1);
      check("stall_addr", 32'(mem_addr_o), 32'd0);
      check("stall_we", 32'(mem_we_o), 32'd0);
      if (i < 4) @(negedge clk_i);
    end
    tick();
    gnt_block = 1'b0;
    finish_sweep("stall");

    // en_i dropped in RD_WAIT with a single-bit error pending on address 3
    load_val = GOLDEN;
    load_val[3] = GOLDEN[3] ^ 13'h100;
    do_load();
    push_sweep();
`ifdef ECC_SCRUB_WRITEBACK_EN
    push_wr(3, GOLDEN[3]);
`endif
    en_i = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!(mem_req_o && mem_gnt_i && !mem_we_o && mem_addr_o == AW'(3)) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    tick();
    en_i = 1'b0;
    wait_idle("endrop_idle");
    check("endrop_q_empty", 32'(exp_q.size()), 32'd0);
    check("endrop_sb", 32'(sb_cnt_o), 32'd1);
    check("endrop_addr", 32'(mem_addr_o), 32'd0);
`ifdef ECC_SCRUB_WRITEBACK_EN
    check("endrop_mem_fixed", 32'(mem[3]), 32'(GOLDEN[3]));
`endif
    pulse_clr();

    // Reset asserted mid-access (writeback request when available, else read)
    load_val = GOLDEN;
    load_val[0] = GOLDEN[0] ^ 13'h001;
    do_load();
`ifdef ECC_SCRUB_WRITEBACK_EN
    push_rd(0);
    wr_block = 1'b1;
`else
    gnt_block = 1'b1;
`endif
    en_i = 1'b1;
    n = 0;
    @(negedge clk_i);
`ifdef ECC_SCRUB_WRITEBACK_EN
    while (!mem_we_o && n < 100) begin
`else
    while (!mem_req_o && n < 100) begin
`endif
      @(negedge clk_i);
      n++;
    end
    check("mid_req_up", 32'(mem_req_o), 32'd1);
    #1;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_req", 32'(mem_req_o), 32'd0);
    check("mid_rst_we", 32'(mem_we_o), 32'd0);
    check("mid_rst_wdata", 32'(mem_wdata_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_cw", 32'(dec_cw_o), 32'd0);
    check("mid_rst_cnts", {sb_cnt_o, db_cnt_o, db_addr_o, db_irq_o, mem_addr_o}, 32'd0);
    en_i = 1'b0;
    exp_q.delete();
    gnt_block = 1'b0;
    wr_block = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    tick();
    check("post_rst_busy", 32'(busy_o), 32'd0);
    check("post_rst_req", 32'(mem_req_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
